sram_port_ctrl: RTL
===================

// Module: sram_port_ctrl
// PURPOSE
//  Initiator for the single-port 512x64 SRAM macro (CEB/WEB/BWEB active-low, 1-cycle registered read).
//  Converts a valid/ready request port plus a valid/ready read-response port into macro pin timing.
//  Samples Q only in its valid cycle. Skid-buffers read data under back-pressure.
//  Optionally zero-fills the array after reset. Sits between cache/BTB logic and each macro instance.
// PARAMETERS
//  DATA_W  64   data width; equals macro Bits and BWEB width
//  ADDR_W  9    address width
//  DEPTH   512  words; init-fill bound, must equal 2**ADDR_W
// PORTS
//  clock       in   1       rising-edge clock; the macro CLK is driven from it
//  reset       in   1       asynchronous, active-high
//  req_valid   in   1       request present
//  req_ready   out  1       request accepted when valid&&ready
//  req_wen     in   1       1=write, 0=read
//  req_addr    in   ADDR_W  word address
//  req_wdata   in   DATA_W  write data
//  req_wmask   in   DATA_W  per-bit write enable, 1=write
//  resp_valid  out  1       read data valid; writes give no response
//  resp_ready  in   1       consumer accepts read data
//  resp_rdata  out  DATA_W  read data
//  init_busy   out  1       zero-fill in progress
//  sram_CEB    out  1       chip enable to macro, active-low
//  sram_WEB    out  1       write enable to macro, active-low
//  sram_BWEB   out  DATA_W  bit write enable to macro, active-low
//  sram_A      out  ADDR_W  address to macro
//  sram_D      out  DATA_W  write data to macro
//  sram_Q      in   DATA_W  macro read data; undefined except in the cycle after a read
// BEHAVIOUR
//  State: INIT, RUN.
//   - rd_inflight: a read was issued in the previous cycle.
//   - hold_valid / hold_data: one-entry skid buffer.
//   - init_cnt: ADDR_W+1 bits.
//  Reset (async) clears rd_inflight, hold_valid, hold_data and init_cnt, and sets state = INIT (macro on) or RUN.
//  While reset is high:
//   - sram_CEB=1, sram_WEB=1, sram_BWEB=all-1, sram_A=0, sram_D=0.
//   - req_ready=0, resp_valid=0.
//  Macro pins are combinational from the accepted request, so the macro samples them at the same edge as the handshake.
//   - Idle: CEB=1, WEB=1, BWEB=all-1, A=0, D=0.
//   - Write: CEB=0, WEB=0, BWEB=~req_wmask, A=req_addr, D=req_wdata.
//   - Read: CEB=0, WEB=1, BWEB=all-1, A=req_addr, D=0.
//  req_ready = (state==RUN) && !hold_valid && !(rd_inflight && !resp_ready).
//   - This has a combinational path from resp_ready. It guarantees no Q is ever lost.
//  Read accepted in cycle N:
//   - Cycle N+1: resp_valid=1, resp_rdata=sram_Q (pass-through).
//   - If resp_ready=0 in N+1, Q is captured into hold_data and hold_valid sets.
//  hold_valid=1:
//   - resp_valid=1 and resp_rdata=hold_data.
//   - hold_valid clears on resp_ready. req_ready is 0 in that cycle and returns to 1 the next cycle.
//  hold_valid and rd_inflight are never both 1.
//  Throughput:
//   - Back-to-back reads sustain 1 per cycle while resp_ready=1.
//   - Writes are accepted in any cycle with req_ready=1, including while a read is in flight. Q capture is unaffected.
//  Read-after-write to the same address in consecutive cycles returns the new data (macro ordering). There is no forwarding.
//  resp_rdata is undefined when resp_valid=0. Benches must not compare it.
// CONFIGURATION
//  SRAM_CTRL_INIT_EN defined:
//   - After reset the block enters INIT and writes zeros to address init_cnt each cycle: CEB=0, WEB=0, BWEB=0, D=0.
//   - init_cnt counts 0..DEPTH-1. After the write to DEPTH-1 it moves to RUN, so INIT lasts exactly DEPTH cycles.
//   - init_busy=1 and req_ready=0 throughout INIT.
//   - Reset asserted mid-INIT restarts the fill at address 0.
//  SRAM_CTRL_INIT_EN undefined:
//   - The INIT state and init_cnt are not built. The block enters RUN directly from reset.
//   - init_busy is tied 0. Array contents are unknown until written.
// TESTING
//  - Init (macro on): release reset -> init_busy=1 for 512 cycles, then req_ready=1; a read of addr 0x1FF returns 0.
//  - Masked write: write 0x1 <- 0xFFFF_FFFF_FFFF_FFFF, then write 0x1 <- 0x0 with mask 0x0000_0000_FFFF_FFFF, then read 0x1 -> 0xFFFF_FFFF_0000_0000.
//  - Streaming reads with resp_ready=1: 8 reads of addrs 0..7 in consecutive cycles -> 8 responses in consecutive cycles, in order, starting 1 cycle after the first accept.
//  - Back-pressure: read 0x10 (=0xA5A5), hold resp_ready=0 for 5 cycles:
//     resp_valid stays 1 with 0xA5A5 throughout; req_ready=0 from the cycle after issue;
//     a single response is delivered when resp_ready rises.
//  - Write during in-flight read: read 0x20 then write 0x21 in the next cycle -> read returns the old 0x20 data; a later read of 0x21 returns the new data.
//  - Reset mid-operation: assert reset with hold_valid=1 -> resp_valid=0 and sram_CEB=1 immediately (async); with the macro on, the fill restarts at address 0.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// Valid/ready front end for a 1-cycle-read single-port SRAM macro; read data is valid the cycle after accept.
// Back-pressure parks one read word in a skid register and stalls req_ready; `SRAM_CTRL_INIT_EN adds a post-reset zero-fill.
module sram_port_ctrl #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_busy,
  output logic              sram_CEB,
  output logic              sram_WEB,
  output logic [DATA_W-1:0] sram_BWEB,
  output logic [ADDR_W-1:0] sram_A,
  output logic [DATA_W-1:0] sram_D,
  input  logic [DATA_W-1:0] sram_Q
);

  if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
    $error("sram_port_ctrl: DEPTH must equal 2**ADDR_W");
  end

  logic              rd_inflight;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic              run;
  logic              accept;

`ifdef SRAM_CTRL_INIT_EN
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [ADDR_W:0] INIT_LAST = (ADDR_W+1)'(DEPTH - 1);

  state_t          state, state_nxt;
  logic [ADDR_W:0] init_cnt, init_cnt_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    if (state == INIT) begin
      init_cnt_nxt = init_cnt + (ADDR_W+1)'(1);
      if (init_cnt == INIT_LAST) state_nxt = RUN;
    end
  end

  assign run       = (state == RUN);
  assign init_busy = (state == INIT);
`else
  assign run       = 1'b1;
  assign init_busy = 1'b0;
`endif

  // Stalling while an unaccepted Q is arriving keeps the skid register to a single entry.
  assign req_ready  = !reset && run && !hold_valid && !(rd_inflight && !resp_ready);
  assign accept     = req_valid && req_ready;
  assign resp_valid = !reset && (hold_valid || rd_inflight);
  assign resp_rdata = hold_valid ? hold_data : sram_Q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_inflight <= 1'b0;
      hold_valid  <= 1'b0;
      hold_data   <= '0;
    end else begin
      rd_inflight <= accept && !req_wen;
      if (rd_inflight && !resp_ready) begin
        hold_valid <= 1'b1;
        hold_data  <= sram_Q;
      end else if (hold_valid && resp_ready) begin
        hold_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    sram_CEB  = 1'b1;
    sram_WEB  = 1'b1;
    sram_BWEB = '1;
    sram_A    = '0;
    sram_D    = '0;
    if (!reset) begin
      if (accept) begin
        sram_CEB = 1'b0;
        sram_A   = req_addr;
        if (req_wen) begin
          sram_WEB  = 1'b0;
          sram_BWEB = ~req_wmask;
          sram_D    = req_wdata;
        end
      end
`ifdef SRAM_CTRL_INIT_EN
      if (state == INIT) begin
        sram_CEB  = 1'b0;
        sram_WEB  = 1'b0;
        sram_BWEB = '0;
        sram_A    = init_cnt[ADDR_W-1:0];
        sram_D    = '0;
      end
`endif
    end
  end

endmodule
